dec_queue: RTL and testbench

//  Buffered RISC-V decode stage between fetch and issue. Queues fetched 32-bit instruction words with their PC in a DEPTH-entry FIFO.

---
 rtl/dec_queue_if.sv | 40 ++++
 rtl/dec_queue.sv | 211 +++++++++++++++++++++
 tb/tb_dec_queue.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_queue_if.sv
// Handshake bundle between fetch (in_*) and issue (out_*) around dec_queue.
//
// valid/ready rule for both directions: a word moves on a rising clock edge
// where valid and ready are both high; while valid is high and ready is low
// the producer keeps valid and its payload unchanged.
interface dec_queue_if #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic            out_with_imm;
    logic [2:0]      out_funct3;
    logic [3:0]      out_cls;
    logic            out_illegal;

    // Decode-queue side: consumes fetch words, produces decoded bundles.
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_imm, out_with_imm, out_funct3, out_cls, out_illegal
    );

    // Environment side: fetch producer plus issue consumer.
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_imm, out_with_imm, out_funct3, out_cls, out_illegal
    );
endinterface

// File: rtl/dec_queue.sv
// Buffered RISC-V decode stage: DEPTH-entry FIFO of {pc, inst} feeding a
// registered decode bundle. Capacity is DEPTH words plus the output register.
module dec_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    dec_queue_if.slave             bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam bit          RV32     = (XLEN == 32);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_W  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG_W  = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_AMO    = 7'b0101111;

    logic [31:0]     mem_inst [DEPTH];
    logic [PC_W-1:0] mem_pc   [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic full, push, pop;

    // A full FIFO refuses words even if the head leaves in the same cycle.
    assign full         = (count == CNT_FULL);
    assign bus.in_ready = ~full;
    assign push         = bus.in_valid & ~full & ~flush;
    assign pop          = (count != '0) & (~bus.out_valid | bus.out_ready) & ~flush;

    // Decode of the FIFO head, captured into the output register on pop.
    logic [31:0]     hi;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, zimm, shamt5, shamt6;
    logic [XLEN-1:0] d_imm;
    logic [4:0]      d_rd;
    logic [3:0]      d_cls;
    logic            d_with_imm, d_bad;

    assign hi     = mem_inst[rd_ptr];
    assign opc    = hi[6:0];
    assign f3     = hi[14:12];
    assign f7     = hi[31:25];
    assign imm_i  = XLEN'($signed(hi[31:20]));
    assign imm_s  = XLEN'($signed({hi[31:25], hi[11:7]}));
    assign imm_b  = XLEN'($signed({hi[31], hi[7], hi[30:25], hi[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({hi[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({hi[31], hi[19:12], hi[20], hi[30:21], 1'b0}));
    assign zimm   = XLEN'(hi[19:15]);
    assign shamt5 = XLEN'(hi[24:20]);
    assign shamt6 = XLEN'(hi[25:20]);

    // Combinational classifier/immediate selector for the head word.
    always_comb begin
        d_cls      = 4'd0;
        d_imm      = imm_i;
        d_with_imm = 1'b1;
        d_rd       = hi[11:7];
        d_bad      = 1'b0;
        case (opc)
            OP_LUI:    begin d_cls = 4'd8; d_imm = imm_u; end
            OP_AUIPC:  begin d_cls = 4'd9; d_imm = imm_u; end
            OP_JAL:    begin d_cls = 4'd6; d_imm = imm_j; d_with_imm = 1'b0; end
            OP_JALR:   d_cls = 4'd7;
            OP_BRANCH: begin
                d_cls = 4'd5; d_imm = imm_b; d_with_imm = 1'b0; d_rd = 5'd0;
            end
            OP_LOAD: begin
                d_cls = 4'd3;
                if (RV32 && (f3 == 3'b011 || f3 == 3'b110)) d_bad = 1'b1;
            end
            OP_STORE: begin
                d_cls = 4'd4; d_imm = imm_s; d_rd = 5'd0;
                if (RV32 && f3 == 3'b011) d_bad = 1'b1;
            end
            OP_IMM: begin
                d_cls = 4'd0;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d_imm = RV32 ? shamt5 : shamt6;
                    if (RV32 && hi[25]) d_bad = 1'b1;
                end
            end
            OP_IMM_W: begin
                d_cls = 4'd1;
                if (f3 == 3'b001 || f3 == 3'b101) d_imm = shamt5;
                if (RV32) d_bad = 1'b1;
            end
            OP_REG: begin
                d_with_imm = 1'b0; d_imm = '0;
                case (f7)
                    7'h00:   d_cls = 4'd0;
                    7'h01:   d_cls = 4'd2;
                    7'h20: begin
                        d_cls = 4'd0;
                        if (f3 != 3'b000 && f3 != 3'b101) d_bad = 1'b1;
                    end
                    default: d_bad = 1'b1;
                endcase
            end
            OP_REG_W: begin
                d_with_imm = 1'b0; d_imm = '0;
                if (RV32) d_bad = 1'b1;
                case (f7)
                    7'h00: begin
                        d_cls = 4'd1;
                        if (f3 != 3'b000 && f3 != 3'b001 && f3 != 3'b101) d_bad = 1'b1;
                    end
                    7'h20: begin
                        d_cls = 4'd1;
                        if (f3 != 3'b000 && f3 != 3'b101) d_bad = 1'b1;
                    end
                    7'h01: begin
                        d_cls = 4'd2;
                        if (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011) d_bad = 1'b1;
                    end
                    default: d_bad = 1'b1;
                endcase
            end
            OP_SYSTEM: begin
                d_cls = 4'd10; d_imm = zimm;
                // csrrw/csrrs/csrrc take rs1 as a register operand
                d_with_imm = ~(f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011);
            end
            OP_FENCE:  d_cls = 4'd11;
            OP_AMO: begin
                d_cls = 4'd12; d_with_imm = 1'b0; d_imm = '0;
                if (RV32 && f3 == 3'b011) d_bad = 1'b1;
            end
            default:   d_bad = 1'b1;
        endcase
        if (d_bad) d_cls = 4'd15;
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= bus.in_inst;
            mem_pc[wr_ptr]   <= bus.in_pc;
        end
    end

    // Pointers and occupancy; flush and reset both empty the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Output bundle register: loads on pop, holds under back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.out_pc       <= '0;
            bus.out_rd       <= '0;
            bus.out_rs1      <= '0;
            bus.out_rs2      <= '0;
            bus.out_imm      <= '0;
            bus.out_with_imm <= 1'b0;
            bus.out_funct3   <= '0;
            bus.out_cls      <= '0;
            bus.out_illegal  <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (pop) begin
            bus.out_valid    <= 1'b1;
            bus.out_pc       <= mem_pc[rd_ptr];
            bus.out_rd       <= d_rd;
            bus.out_rs1      <= hi[19:15];
            bus.out_rs2      <= hi[24:20];
            bus.out_imm      <= d_imm;
            bus.out_with_imm <= d_with_imm;
            bus.out_funct3   <= f3;
            bus.out_cls      <= d_cls;
            bus.out_illegal  <= d_bad;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dec_queue.sv
// Bench for dec_queue: queue-level model of the XLEN=64 instance checked every
// cycle, directed literal checks on both an XLEN=64 and an XLEN=32 instance.
module tb_dec_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       flush32;
    logic [2:0] count64;
    logic [2:0] count32;
    bit         cmp_en;

    always #5 clk = ~clk;

    dec_queue_if #(.XLEN(64), .PC_W(64)) bus64 ();
    dec_queue_if #(.XLEN(32), .PC_W(32)) bus32 ();

    dec_queue #(.XLEN(64), .DEPTH(DEPTH), .PC_W(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus64.slave), .count(count64)
    );
    dec_queue #(.XLEN(32), .DEPTH(DEPTH), .PC_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush32), .bus(bus32.slave), .count(count32)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic        with_imm;
        logic [2:0]  f3;
        logic [3:0]  cls;
        logic        illegal;
        logic        imm_care;
    } dec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } word_t;

    // RV64 decode written straight from the encoding tables.
    function automatic dec_t model_decode(input logic [31:0] i);
        dec_t d;
        logic [63:0] ii, si, bi, ui, ji;
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3 = i[14:12];
        f7 = i[31:25];
        ii = {{52{i[31]}}, i[31:20]};
        si = {{52{i[31]}}, i[31:25], i[11:7]};
        bi = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        ui = {{32{i[31]}}, i[31:12], 12'h000};
        ji = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.f3 = f3;
        d.imm = ii; d.with_imm = 1'b1; d.cls = 4'd0; d.illegal = 1'b0; d.imm_care = 1'b1;
        case (i[6:0])
            7'h37: begin d.cls = 8; d.imm = ui; end
            7'h17: begin d.cls = 9; d.imm = ui; end
            7'h6f: begin d.cls = 6; d.imm = ji; d.with_imm = 0; end
            7'h67: d.cls = 7;
            7'h63: begin d.cls = 5; d.imm = bi; d.with_imm = 0; d.rd = 0; end
            7'h03: d.cls = 3;
            7'h23: begin d.cls = 4; d.imm = si; d.rd = 0; end
            7'h13: begin
                d.cls = 0;
                if (f3 == 1 || f3 == 5) d.imm = {58'd0, i[25:20]};
            end
            7'h1b: begin
                d.cls = 1;
                if (f3 == 1 || f3 == 5) d.imm = {59'd0, i[24:20]};
            end
            7'h33: begin
                d.with_imm = 0; d.imm_care = 0;
                if (f7 == 7'h01) d.cls = 2;
                else if (f7 == 7'h00) d.cls = 0;
                else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) d.cls = 0;
                else d.illegal = 1;
            end
            7'h3b: begin
                d.with_imm = 0; d.imm_care = 0;
                if (f7 == 7'h01 && (f3 inside {3'd0, 3'd4, 3'd5, 3'd6, 3'd7})) d.cls = 2;
                else if (f7 == 7'h00 && (f3 inside {3'd0, 3'd1, 3'd5})) d.cls = 1;
                else if (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})) d.cls = 1;
                else d.illegal = 1;
            end
            7'h73: begin
                d.cls = 10; d.imm = {59'd0, i[19:15]};
                d.with_imm = !(f3 inside {3'd1, 3'd2, 3'd3});
            end
            7'h0f: begin d.cls = 11; d.imm_care = 0; end
            7'h2f: begin d.cls = 12; d.with_imm = 0; d.imm_care = 0; end
            default: d.illegal = 1;
        endcase
        if (d.illegal) d.cls = 15;
        return d;
    endfunction

    word_t mq[$];
    word_t mw;
    bit    mv;

    // Queue-level behaviour of the XLEN=64 instance, advanced at each edge.
    always @(posedge clk or posedge rst) begin : model_step
        bit m_full, m_push, m_load;
        word_t nw;
        if (rst) begin
            mq.delete();
            mv = 0;
        end else if (flush) begin
            mq.delete();
            mv = 0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_push = bus64.in_valid && !m_full;
            m_load = (mq.size() > 0) && (!mv || bus64.out_ready);
            if (m_load) begin
                mw = mq.pop_front();
                mv = 1;
            end else if (bus64.out_ready) begin
                mv = 0;
            end
            if (m_push) begin
                nw.pc = bus64.in_pc;
                nw.inst = bus64.in_inst;
                mq.push_back(nw);
            end
        end
    end

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    // Scoreboard: compare the XLEN=64 instance with the model every cycle.
    always @(negedge clk) begin : compare
        dec_t e;
        if (!rst && cmp_en) begin
            check("count", 64'(count64), 64'(mq.size()));
            check("in_ready", 64'(bus64.in_ready), 64'(mq.size() != DEPTH));
            check("out_valid", 64'(bus64.out_valid), 64'(mv));
            if (mv && bus64.out_valid) begin
                e = model_decode(mw.inst);
                check("pc", bus64.out_pc, mw.pc);
                check("cls", 64'(bus64.out_cls), 64'(e.cls));
                check("illegal", 64'(bus64.out_illegal), 64'(e.illegal));
                if (!e.illegal) begin
                    check("rd", 64'(bus64.out_rd), 64'(e.rd));
                    check("rs1", 64'(bus64.out_rs1), 64'(e.rs1));
                    check("rs2", 64'(bus64.out_rs2), 64'(e.rs2));
                    check("funct3", 64'(bus64.out_funct3), 64'(e.f3));
                    check("with_imm", 64'(bus64.out_with_imm), 64'(e.with_imm));
                    if (e.imm_care) check("imm", bus64.out_imm, e.imm);
                end
            end
            if (bus64.out_valid && bus64.out_ready) got_q.push_back(bus64.out_pc);
        end
    end

    // ---------------- drivers ----------------
    // Called #1 after an edge; the word is offered for exactly one edge.
    task automatic send64(input logic [63:0] pc, input logic [31:0] inst);
        bus64.in_valid = 1'b1;
        bus64.in_pc    = pc;
        bus64.in_inst  = inst;
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] pc, input logic [31:0] inst);
        bus32.in_valid = 1'b1;
        bus32.in_pc    = pc;
        bus32.in_inst  = inst;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
    endtask

    logic [31:0] stream [18] = '{
        32'h123452B7, 32'h00001317, 32'h008000EF, 32'h00008067,
        32'h00813503, 32'h00A13823, 32'h002081B3, 32'h402081B3,
        32'h022081B3, 32'h002081BB, 32'h202081B3, 32'h300110F3,
        32'h3002D0F3, 32'h0FF0000F, 32'h0020B1AF, 32'h4280D093,
        32'h4030D09B, 32'h0000007F
    };

    initial begin
        rst = 1'b1; flush = 1'b0; flush32 = 1'b0; cmp_en = 1'b0;
        bus64.in_valid = 0; bus64.in_inst = 0; bus64.in_pc = 0; bus64.out_ready = 1;
        bus32.in_valid = 0; bus32.in_inst = 0; bus32.in_pc = 0; bus32.out_ready = 1;
        repeat (2) @(posedge clk); #1;

        // reset state
        check("rst_count", 64'(count64), 64'd0);
        check("rst_valid", 64'(bus64.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus64.in_ready), 64'd1);
        check("rst_pc", bus64.out_pc, 64'd0);
        check("rst_cls", 64'(bus64.out_cls), 64'd0);
        rst = 1'b0; cmp_en = 1'b1;

        // addi x1,x0,5: visible after the second edge
        send64(64'h1000, 32'h00500093);
        @(negedge clk);
        check("lat_early", 64'(bus64.out_valid), 64'd0);
        @(negedge clk);
        check("t1_valid", 64'(bus64.out_valid), 64'd1);
        check("t1_rd", 64'(bus64.out_rd), 64'd1);
        check("t1_rs1", 64'(bus64.out_rs1), 64'd0);
        check("t1_imm", bus64.out_imm, 64'd5);
        check("t1_cls", 64'(bus64.out_cls), 64'd0);
        check("t1_with_imm", 64'(bus64.out_with_imm), 64'd1);
        @(posedge clk); #1;

        // mixed-class stream with intermittent back-pressure
        bus64.in_valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            bus64.in_pc   = 64'h100 + 64'(4 * k);
            bus64.in_inst = stream[k];
            bus64.out_ready = (k % 3 != 2);
            do begin
                @(posedge clk); #1;
            end while (!(bus64.in_ready || count64 != 3'd4) && 0);
            if (!bus64.in_ready) begin
                bus64.out_ready = 1'b1;
                @(posedge clk); #1;
            end
        end
        bus64.in_valid = 1'b0; bus64.out_ready = 1'b1;
        repeat (8) @(posedge clk); #1;

        // beq x0,x0,-4
        send64(64'h2000, 32'hFE000EE3);
        repeat (2) @(negedge clk);
        check("beq_cls", 64'(bus64.out_cls), 64'd5);
        check("beq_rd", 64'(bus64.out_rd), 64'd0);
        check("beq_imm", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_with_imm", 64'(bus64.out_with_imm), 64'd0);

        // slli x1,x1,32 is legal on RV64
        @(posedge clk); #1;
        send64(64'h2100, 32'h02009093);
        repeat (2) @(negedge clk);
        check("slli64_illegal", 64'(bus64.out_illegal), 64'd0);
        check("slli64_imm", bus64.out_imm, 64'd32);
        @(posedge clk); #1;

        // capacity: 6 offered with the consumer stalled, 5 taken
        bus64.out_ready = 1'b0;
        bus64.in_valid  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus64.in_pc   = 64'h3000 + 64'(4 * k);
            bus64.in_inst = 32'h00000093 | (32'(k) << 20);
            @(posedge clk); #1;
        end
        bus64.in_valid = 1'b0;
        check("cap_in_ready", 64'(bus64.in_ready), 64'd0);
        check("cap_count", 64'(count64), 64'd4);
        check("cap_valid", 64'(bus64.out_valid), 64'd1);
        exp_q.delete();
        for (int k = 0; k < 5; k++) exp_q.push_back(64'h3000 + 64'(4 * k));
        got_q.delete();
        bus64.out_ready = 1'b1;
        for (int c = 0; c < 20 && got_q.size() < 5; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("cap_delivered", 64'(got_q.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got_q.size()) check("cap_order", got_q[k], exp_q[k]);
            else check("cap_order_missing", 64'hDEAD, exp_q[k]);
        end
        @(posedge clk); #1;

        // flush with 3 queued and a held bundle
        bus64.out_ready = 1'b0;
        bus64.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus64.in_pc   = 64'h5000 + 64'(4 * k);
            bus64.in_inst = 32'h00100093;
            @(posedge clk); #1;
        end
        check("pre_flush_count", 64'(count64), 64'd3);
        check("pre_flush_valid", 64'(bus64.out_valid), 64'd1);
        bus64.in_pc = 64'h5100;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus64.in_valid = 1'b0;
        check("flush_valid", 64'(bus64.out_valid), 64'd0);
        check("flush_count", 64'(count64), 64'd0);
        check("flush_in_ready", 64'(bus64.in_ready), 64'd1);
        got_q.delete();
        bus64.out_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        check("no_stale", 64'(got_q.size()), 64'd0);

        // compressed-looking word is delivered as illegal
        send64(64'h6000, 32'h00004501);
        repeat (2) @(negedge clk);
        check("rvc_illegal", 64'(bus64.out_illegal), 64'd1);
        check("rvc_cls", 64'(bus64.out_cls), 64'd15);
        @(posedge clk); #1;

        // asynchronous reset in the middle of a burst
        bus64.out_ready = 1'b0;
        bus64.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus64.in_pc   = 64'h7000 + 64'(4 * k);
            bus64.in_inst = 32'h00500093;
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(bus64.out_valid), 64'd0);
        check("arst_count", 64'(count64), 64'd0);
        check("arst_in_ready", 64'(bus64.in_ready), 64'd1);
        check("arst_pc", bus64.out_pc, 64'd0);
        check("arst_imm", bus64.out_imm, 64'd0);
        bus64.in_valid = 1'b0; bus64.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // RV32 instance: *W ops and shamt bit 5 are illegal
        send32(32'h100, 32'h0010009B);
        repeat (2) @(negedge clk);
        check("rv32_addiw_illegal", 64'(bus32.out_illegal), 64'd1);
        check("rv32_addiw_cls", 64'(bus32.out_cls), 64'd15);
        @(posedge clk); #1;
        send32(32'h104, 32'h02009093);
        repeat (2) @(negedge clk);
        check("rv32_slli_illegal", 64'(bus32.out_illegal), 64'd1);
        check("rv32_slli_cls", 64'(bus32.out_cls), 64'd15);
        @(posedge clk); #1;
        send32(32'h108, 32'hFFF00093);
        repeat (2) @(negedge clk);
        check("rv32_addi_illegal", 64'(bus32.out_illegal), 64'd0);
        check("rv32_addi_imm", 64'(bus32.out_imm), 64'hFFFF_FFFF);
        check("rv32_addi_pc", 64'(bus32.out_pc), 64'h108);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
